// File: rtl/i2c_pkg.sv
// i2c_pkg: shared command codes, register select, status codes and sequencer states
package i2c_pkg;
    localparam logic [7:0] CMD_START   = 8'd1;
    localparam logic [7:0] CMD_STOP    = 8'd2;
    localparam logic [7:0] CMD_RD_ACK  = 8'd4;
    localparam logic [7:0] CMD_RD_NACK = 8'd5;
    localparam logic [7:0] CMD_WRITE   = 8'd6;
    localparam logic AD_DATA = 1'b0;
    localparam logic AD_CMD  = 1'b1;
    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_NACK    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_START   = 4'd1;
    localparam logic [3:0] S_ADDR_W  = 4'd2;
    localparam logic [3:0] S_REG     = 4'd3;
    localparam logic [3:0] S_DATA    = 4'd4;
    localparam logic [3:0] S_RESTART = 4'd5;
    localparam logic [3:0] S_ADDR_R  = 4'd6;
    localparam logic [3:0] S_READ    = 4'd7;
    localparam logic [3:0] S_STOP    = 4'd8;
    localparam logic [3:0] S_FINISH  = 4'd9;
endpackage

// File: rtl/i2c_cmd_issuer.sv
// i2c_cmd_issuer: issues one master step (optional data write + command write) and waits for DONE
// Ports: clk/reset (async, active-low); go + is_write_byte/cmd/wr_byte start a step;
// m_* drive/observe the master; done/nack/timeout are one-cycle step results.
module i2c_cmd_issuer
    import i2c_pkg::*;
#(
    parameter int TIMEOUT = 4096,
    parameter int GUARD   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       is_write_byte,
    input  logic [7:0] cmd,
    input  logic [7:0] wr_byte,
    input  logic       m_done,
    input  logic       m_error,
    output logic       m_cs,
    output logic       m_we,
    output logic       m_ad,
    output logic [7:0] m_di,
    output logic       done,
    output logic       nack,
    output logic       timeout
);
    localparam logic [1:0] P_IDLE = 2'd0;
    localparam logic [1:0] P_CMD  = 2'd1;
    localparam logic [1:0] P_WAIT = 2'd2;

    logic [1:0]  phase;
    logic [7:0]  pend_cmd;
    logic        pend_wr;
    logic [15:0] cnt;

    // cnt is 0 in the command strobe cycle, so DONE is first honoured GUARD+1 cycles later
    assign done    = phase == P_WAIT && m_done && cnt > 16'(GUARD);
    assign nack    = done && m_error && pend_wr;
    assign timeout = phase == P_WAIT && !done && cnt == 16'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase    <= P_IDLE;
            pend_cmd <= '0;
            pend_wr  <= 1'b0;
            cnt      <= '0;
            m_cs     <= 1'b0;
            m_we     <= 1'b0;
            m_ad     <= AD_DATA;
            m_di     <= '0;
        end else begin
            m_cs <= 1'b0;
            m_we <= 1'b0;
            m_ad <= AD_DATA;
            m_di <= '0;
            if (go) begin
                m_cs     <= 1'b1;
                m_we     <= 1'b1;
                m_ad     <= is_write_byte ? AD_DATA : AD_CMD;
                m_di     <= is_write_byte ? wr_byte : cmd;
                pend_cmd <= cmd;
                pend_wr  <= is_write_byte;
                cnt      <= '0;
                phase    <= is_write_byte ? P_CMD : P_WAIT;
            end else if (phase == P_CMD) begin
                m_cs  <= 1'b1;
                m_we  <= 1'b1;
                m_ad  <= AD_CMD;
                m_di  <= pend_cmd;
                cnt   <= '0;
                phase <= P_WAIT;
            end else if (phase == P_WAIT) begin
                cnt <= cnt + 16'd1;
                if (done || timeout) phase <= P_IDLE;
            end
        end
    end
endmodule

// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: turns one register read/write request into the full I2C master command sequence
// Ports: clk/reset (async, active-low); req/rw/dev_addr/reg_addr/wdata request;
// busy/fin_p/rdata/err result; m_cs/m_we/m_ad/m_di/m_do/m_done/m_error master interface.
module i2c_reg_seq
    import i2c_pkg::*;
#(
    parameter int TIMEOUT = 4096,
    parameter int GUARD   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       fin_p,
    output logic [7:0] rdata,
    output logic [1:0] err,
    output logic       m_cs,
    output logic       m_we,
    output logic       m_ad,
    output logic [7:0] m_di,
    input  logic [7:0] m_do,
    input  logic       m_done,
    input  logic       m_error
);
    logic [3:0] state, nxt, succ;
    logic       rw_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q, wdata_q;
    logic       go, is_wr, done, nack, timeout;
    logic [7:0] cmd, wr_byte;

    assign busy  = state != S_IDLE && state != S_FINISH;
    assign fin_p = state == S_FINISH;

    always_comb begin
        succ = S_FINISH;
        case (state)
            S_START:   succ = S_ADDR_W;
            S_ADDR_W:  succ = S_REG;
            S_REG:     succ = rw_q ? S_RESTART : S_DATA;
            S_DATA:    succ = S_STOP;
            S_RESTART: succ = S_ADDR_R;
            S_ADDR_R:  succ = S_READ;
            S_READ:    succ = S_STOP;
            default:   succ = S_FINISH;
        endcase
    end

    // a NACK on any address/data byte still releases the bus via STOP; a timeout does not
    always_comb begin
        nxt = state;
        if (state == S_IDLE) nxt = req ? S_START : S_IDLE;
        else if (state == S_FINISH) nxt = S_IDLE;
        else if (timeout) nxt = S_FINISH;
        else if (nack) nxt = S_STOP;
        else if (done) nxt = succ;
    end

    // step parameters are taken from the state being entered so its strobe lands next cycle
    assign go      = nxt != state && nxt != S_IDLE && nxt != S_FINISH;
    assign is_wr   = nxt == S_ADDR_W || nxt == S_REG || nxt == S_DATA || nxt == S_ADDR_R;
    assign cmd     = (nxt == S_START || nxt == S_RESTART) ? CMD_START :
                     nxt == S_READ ? CMD_RD_NACK :
                     nxt == S_STOP ? CMD_STOP : CMD_WRITE;
    assign wr_byte = nxt == S_ADDR_W ? {dev_q, 1'b0} :
                     nxt == S_ADDR_R ? {dev_q, 1'b1} :
                     nxt == S_REG ? reg_q : wdata_q;

    i2c_cmd_issuer #(.TIMEOUT(TIMEOUT), .GUARD(GUARD)) u_issuer (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .is_write_byte (is_wr),
        .cmd           (cmd),
        .wr_byte       (wr_byte),
        .m_done        (m_done),
        .m_error       (m_error),
        .m_cs          (m_cs),
        .m_we          (m_we),
        .m_ad          (m_ad),
        .m_di          (m_di),
        .done          (done),
        .nack          (nack),
        .timeout       (timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            rw_q    <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            err     <= ERR_OK;
        end else begin
            state <= nxt;
            if (state == S_IDLE && req) begin
                rw_q    <= rw;
                dev_q   <= dev_addr;
                reg_q   <= reg_addr;
                wdata_q <= wdata;
                err     <= ERR_OK;
            end
            if (timeout) err <= ERR_TIMEOUT;
            if (nack) err <= ERR_NACK;
            if (state == S_READ && done) rdata <= m_do;
        end
    end
endmodule
